shift_right_pipe: RTL

//  16-bit right-direction shift unit: SRL, SRA and ROR by 0..15, the counterpart of the combinational left shifter.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_right_stage.sv | 79 +++++++
 rtl/shift_right_pipe.sv | 88 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the left/right shift units: mode encodings and the
// shift-amount decode into per-stage digits.
package shift_pkg;

  localparam logic [1:0] SH_SRL = 2'b00;
  localparam logic [1:0] SH_SRA = 2'b01;
  localparam logic [1:0] SH_ROR = 2'b10;

  // n = a + 3b + 9c, returned as {c, b[1:0], a[1:0]}
  function automatic logic [4:0] amt_decode(input logic [3:0] n);
    logic       c;
    logic [3:0] r;
    logic [3:0] b;
    logic [3:0] a;
    c = (n >= 4'd9);
    r = c ? (n - 4'd9) : n;
    b = r / 4'd3;
    a = r % 4'd3;
    return {c, b[1:0], a[1:0]};
  endfunction

endpackage

// File: rtl/shift_right_stage.sv
// One stage of the right-shift pipeline: shifts the incoming operand by
// 0, STEP or 2*STEP according to its amount digit, then registers it.
module shift_right_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             next_stall,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [1:0]       prev_mode,
  input  logic [4:0]       prev_dig,
  output logic             vld,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       mode,
  output logic [4:0]       dig,
  output logic             stall
);

  logic [1:0]       digit;
  logic [3:0]       k;
  logic [WIDTH-1:0] shifted;

  function automatic logic [WIDTH-1:0] shift_r(input logic [WIDTH-1:0] d,
                                               input logic [1:0]       m,
                                               input logic [3:0]       amt);
    logic [2*WIDTH-1:0] dd;
    logic [WIDTH-1:0]   res;
    dd = '0;
    case (m)
      SH_SRA:  res = $unsigned($signed(d) >>> amt);
      SH_ROR: begin
        dd  = {d, d} >> amt;
        res = dd[WIDTH-1:0];
      end
      default: res = d >> amt;
    endcase
    return res;
  endfunction

  always_comb begin
    digit = 2'd0;
    if (STEP == 1)
      digit = prev_dig[1:0];
    else if (STEP == 3)
      digit = prev_dig[3:2];
    else
      digit = {1'b0, prev_dig[4]};
    k       = 4'(digit) * 4'(STEP);
    shifted = shift_r(prev_data, prev_mode, k);
  end

  assign stall = vld & next_stall;

  // stage register: a stalled stage keeps its contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
      mode <= 2'b00;
      dig  <= 5'd0;
    end else begin
      if (flush)
        vld <= 1'b0;
      else if (!stall)
        vld <= prev_vld;
      if (!stall && prev_vld && !flush) begin
        data <= shifted;
        mode <= prev_mode;
        dig  <= prev_dig;
      end
    end
  end

endmodule

// File: rtl/shift_right_pipe.sv
// Three-stage pipelined right shifter (SRL/SRA/ROR by 0..15) with
// valid/ready handshake on both sides; results return in order.
module shift_right_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  logic             vld_p0, vld_p1, vld_p2, vld_p3;
  logic [WIDTH-1:0] data_p1, data_p2, data_p3;
  logic [1:0]       mode_p1, mode_p2;
  logic [4:0]       dig_p0, dig_p1, dig_p2;
  logic             stall_p1, stall_p2, stall_p3;

  assign dig_p0   = amt_decode(in_amt);
  assign vld_p0   = in_valid & ~flush;
  assign in_ready = ~stall_p1 & ~flush;

  // stage 1: shift by a (0/1/2)
  shift_right_stage #(.WIDTH(WIDTH), .STEP(1)) u_stage1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .next_stall (stall_p2),
    .prev_vld   (vld_p0),
    .prev_data  (in_data),
    .prev_mode  (in_mode),
    .prev_dig   (dig_p0),
    .vld        (vld_p1),
    .data       (data_p1),
    .mode       (mode_p1),
    .dig        (dig_p1),
    .stall      (stall_p1)
  );

  // stage 2: shift by 3b (0/3/6)
  shift_right_stage #(.WIDTH(WIDTH), .STEP(3)) u_stage2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .next_stall (stall_p3),
    .prev_vld   (vld_p1),
    .prev_data  (data_p1),
    .prev_mode  (mode_p1),
    .prev_dig   (dig_p1),
    .vld        (vld_p2),
    .data       (data_p2),
    .mode       (mode_p2),
    .dig        (dig_p2),
    .stall      (stall_p2)
  );

  // stage 3: shift by 9c (0/9), drives the output port directly
  shift_right_stage #(.WIDTH(WIDTH), .STEP(9)) u_stage3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .next_stall (~out_ready),
    .prev_vld   (vld_p2),
    .prev_data  (data_p2),
    .prev_mode  (mode_p2),
    .prev_dig   (dig_p2),
    .vld        (vld_p3),
    .data       (data_p3),
    .mode       (),
    .dig        (),
    .stall      (stall_p3)
  );

  assign out_valid = vld_p3;
  assign out_data  = data_p3;
  assign out_zero  = ~|data_p3;

endmodule
